repairmb_degrade_initiator: RTL and testbench

//  Module-side initiator of the MBINIT.REPAIRMB degrade exchange; feeds the partner-side lane checker.

---
 rtl/repairmb_degrade_initiator_if.sv | 40 ++++
 rtl/repairmb_degrade_initiator.sv | 142 ++++++++++++++
 tb/tb_repairmb_degrade_initiator.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/repairmb_degrade_initiator_if.sv
// Sideband / lane-result bundle for the REPAIRMB degrade initiator.
//   master : the initiator (drives o_*, samples i_*)
//   slave  : the environment (lane checker results, sideband TX/RX, training FSM)
// Signals:
//   i_start, i_second_check            run control from the training sequencer
//   i_result_valid, i_lane_result      per-lane D2C point-test results
//   o_sb_valid, i_sb_ready, o_sb_lanes sideband request carrying the lanes code
//   i_sb_rsp_valid, i_sb_rsp_lanes     partner echo of the lanes code
//   o_done + one of o_continue / o_go_to_repeat / o_go_to_train_error
interface repairmb_degrade_initiator_if #(
    parameter int NUM_LANES = 16
);
    logic                 i_start;
    logic                 i_second_check;
    logic                 i_result_valid;
    logic [NUM_LANES-1:0] i_lane_result;
    logic                 o_sb_valid;
    logic                 i_sb_ready;
    logic [1:0]           o_sb_lanes;
    logic                 i_sb_rsp_valid;
    logic [1:0]           i_sb_rsp_lanes;
    logic                 o_done;
    logic                 o_continue;
    logic                 o_go_to_repeat;
    logic                 o_go_to_train_error;

    modport master (
        input  i_start, i_second_check, i_result_valid, i_lane_result,
               i_sb_ready, i_sb_rsp_valid, i_sb_rsp_lanes,
        output o_sb_valid, o_sb_lanes, o_done, o_continue,
               o_go_to_repeat, o_go_to_train_error
    );

    modport slave (
        output i_start, i_second_check, i_result_valid, i_lane_result,
               i_sb_ready, i_sb_rsp_valid, i_sb_rsp_lanes,
        input  o_sb_valid, o_sb_lanes, o_done, o_continue,
               o_go_to_repeat, o_go_to_train_error
    );
endinterface

// File: rtl/repairmb_degrade_initiator.sv
// Module-side initiator of the MBINIT.REPAIRMB degrade exchange.
// Reduces per-lane point-test results to a 2-bit functional-lanes code
// ({hi_half_ok, lo_half_ok}), sends it over sideband, waits for the partner
// echo and reports continue / repeat / train-error with a one-cycle done.
// A second pass (i_second_check=1) confirms the code matches the last
// first-pass code.
// Ports:
//   CLK    clock
//   rst_n  synchronous active-low reset
//   bus    repairmb_degrade_initiator_if.master (handshake + result flags)
// Optional feature: define REPAIRMB_RSP_TIMEOUT_EN to enable the WAIT_RSP
// timeout (TIMEOUT_CYC cycles, TMR_W-bit saturating timer). Without it the
// initiator waits for a response or abort indefinitely.
module repairmb_degrade_initiator #(
    parameter int NUM_LANES   = 16,
    parameter int TIMEOUT_CYC = 8000,
    parameter int TMR_W       = 16
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    repairmb_degrade_initiator_if.master  bus
);
    typedef enum logic [2:0] {IDLE, WAIT_RES, SEND, WAIT_RSP, FIN} state_t;

    state_t     state;
    logic       sc;
    logic [1:0] code;
    logic [1:0] prev_code;
    logic       sb_valid;
    logic [1:0] sb_lanes;
    logic       done, cont, rep, err;

    logic [1:0] lane_code;
    logic       rsp_match;
    logic       timeout;
    logic       dec_cont, dec_rep, dec_err;

    assign lane_code = {&bus.i_lane_result[NUM_LANES-1:NUM_LANES/2],
                        &bus.i_lane_result[NUM_LANES/2-1:0]};
    assign rsp_match = bus.i_sb_rsp_valid && (bus.i_sb_rsp_lanes == code);

`ifdef REPAIRMB_RSP_TIMEOUT_EN
    logic [TMR_W-1:0] timer;

    assign timeout = (timer == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK) begin
        if (!rst_n)
            timer <= '0;
        else if (state == SEND)
            timer <= '0;
        else if (state == WAIT_RSP && timer != '1)
            timer <= timer + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // Outcome if the exchange finishes this cycle. Anything that is not a
    // matching echo (mismatch or timeout) lands in train error.
    always_comb begin
        dec_cont = 1'b0;
        dec_rep  = 1'b0;
        dec_err  = 1'b1;
        if (rsp_match) begin
            if (sc) begin
                if (code == prev_code) begin
                    dec_cont = 1'b1;
                    dec_err  = 1'b0;
                end
            end else begin
                case (code)
                    2'b11:        begin dec_cont = 1'b1; dec_err = 1'b0; end
                    2'b01, 2'b10: begin dec_rep  = 1'b1; dec_err = 1'b0; end
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state     <= IDLE;
            sc        <= 1'b0;
            code      <= 2'b00;
            prev_code <= 2'b00;
            sb_valid  <= 1'b0;
            sb_lanes  <= 2'b00;
            done      <= 1'b0;
            cont      <= 1'b0;
            rep       <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            cont <= 1'b0;
            rep  <= 1'b0;
            err  <= 1'b0;
            if (state != IDLE && !bus.i_start) begin
                // Abort: silent return to IDLE, prev_code preserved.
                state    <= IDLE;
                sb_valid <= 1'b0;
                sb_lanes <= 2'b00;
            end else begin
                case (state)
                    IDLE: if (bus.i_start) begin
                        sc    <= bus.i_second_check;
                        state <= WAIT_RES;
                    end
                    WAIT_RES: if (bus.i_result_valid) begin
                        code     <= lane_code;
                        sb_valid <= 1'b1;
                        sb_lanes <= lane_code;
                        state    <= SEND;
                    end
                    SEND: if (bus.i_sb_ready) begin
                        sb_valid <= 1'b0;
                        sb_lanes <= 2'b00;
                        state    <= WAIT_RSP;
                    end
                    WAIT_RSP: if (bus.i_sb_rsp_valid || timeout) begin
                        done  <= 1'b1;
                        cont  <= dec_cont;
                        rep   <= dec_rep;
                        err   <= dec_err;
                        state <= FIN;
                        if (!sc)
                            prev_code <= code;
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_sb_valid          = sb_valid;
    assign bus.o_sb_lanes          = sb_lanes;
    assign bus.o_done              = done;
    assign bus.o_continue          = cont;
    assign bus.o_go_to_repeat      = rep;
    assign bus.o_go_to_train_error = err;
endmodule

// File: tb/tb_repairmb_degrade_initiator.sv
// Scoreboard bench for repairmb_degrade_initiator: stimulus pushes the
// expected request code and outcome flags into queues; a negedge monitor
// pops and compares on every sideband handshake and every done pulse.
module tb_repairmb_degrade_initiator;
    localparam logic [2:0] CONT = 3'b100, REP = 3'b010, ERR = 3'b001;

    logic CLK = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    logic [1:0] lq[$];
    logic [2:0] rq[$];

    repairmb_degrade_initiator_if #(.NUM_LANES(16)) bus();

    repairmb_degrade_initiator #(
        .NUM_LANES(16), .TIMEOUT_CYC(20), .TMR_W(16)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.o_sb_valid, bus.o_sb_lanes, bus.o_done, bus.o_continue,
                bus.o_go_to_repeat, bus.o_go_to_train_error};
    endfunction

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (rst_n) begin
            if (bus.o_sb_valid && bus.i_sb_ready) begin
                if (lq.size() == 0) check("unexpected_handshake", 1, 0);
                else check("sb_lanes", bus.o_sb_lanes, lq.pop_front());
            end
            if (!bus.o_sb_valid) check("sb_lanes_idle_zero", bus.o_sb_lanes, 2'b00);
            if (bus.o_done) begin
                done_cnt++;
                if (rq.size() == 0) check("unexpected_done", 1, 0);
                else check("result_flags",
                           {bus.o_continue, bus.o_go_to_repeat, bus.o_go_to_train_error},
                           rq.pop_front());
            end else if (bus.o_continue || bus.o_go_to_repeat || bus.o_go_to_train_error) begin
                check("flags_without_done", 1, 0);
            end
        end
    end

    // rsp_dly < 0: no response. Response driven rsp_dly cycles after the
    // handshake edge; exp_lat counts negedges from handshake edge to done.
    task automatic run(input logic sc, input logic [15:0] lanes, input int rdy_dly,
                       input int rsp_dly, input logic [1:0] rsp,
                       input logic [1:0] exp_code, input logic [2:0] exp_flags,
                       input int exp_lat);
        int lat = 0;
        lq.push_back(exp_code);
        rq.push_back(exp_flags);
        @(posedge CLK) #1;
        bus.i_start = 1'b1; bus.i_second_check = sc;
        @(posedge CLK) #1;
        bus.i_result_valid = 1'b1; bus.i_lane_result = lanes;
        @(posedge CLK) #1;
        bus.i_result_valid = 1'b0; bus.i_lane_result = '0;
        bus.i_sb_ready = (rdy_dly == 0);
        @(negedge CLK);
        check("sb_valid_latency", {bus.o_sb_valid, bus.o_sb_lanes}, {1'b1, exp_code});
        for (int i = 1; i <= rdy_dly; i++) begin
            @(posedge CLK) #1;
            bus.i_sb_ready = (i == rdy_dly);
            @(negedge CLK);
            check("sb_hold", {bus.o_sb_valid, bus.o_sb_lanes}, {1'b1, exp_code});
        end
        @(posedge CLK) #1;
        bus.i_sb_ready = 1'b0;
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            if (c - 1 == rsp_dly) begin
                bus.i_sb_rsp_valid = 1'b1; bus.i_sb_rsp_lanes = rsp;
            end
            @(negedge CLK);
            if (bus.o_done) lat = c;
            @(posedge CLK) #1;
            bus.i_sb_rsp_valid = 1'b0; bus.i_sb_rsp_lanes = 2'b00;
        end
        check("done_latency", lat, exp_lat);
        bus.i_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        rst_n = 1'b0;
        bus.i_start = 0; bus.i_second_check = 0; bus.i_result_valid = 0;
        bus.i_lane_result = '0; bus.i_sb_ready = 0;
        bus.i_sb_rsp_valid = 0; bus.i_sb_rsp_lanes = 2'b00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs", outs(), 7'b0);
        @(posedge CLK) #1;
        rst_n = 1'b1;

        // all lanes, then a second pass against prev_code=11
        run(1'b0, 16'hFFFF, 0, 5, 2'b11, 2'b11, CONT, 7);
        run(1'b1, 16'hFFFF, 0, 2, 2'b11, 2'b11, CONT, 4);
        // lower half only, then stable and changed second passes
        run(1'b0, 16'h00FF, 0, 3, 2'b01, 2'b01, REP, 5);
        run(1'b1, 16'h00FF, 2, 1, 2'b01, 2'b01, CONT, 3);
        run(1'b1, 16'hFF00, 0, 0, 2'b10, 2'b10, ERR, 2);
        // upper half only
        run(1'b0, 16'hFF00, 1, 4, 2'b10, 2'b10, REP, 6);
        // no functional half
        run(1'b0, 16'h7FFE, 0, 2, 2'b00, 2'b00, ERR, 4);
        // echo mismatch with ready held off for 10 cycles
        run(1'b0, 16'hFFFF, 10, 2, 2'b01, 2'b11, ERR, 4);
`ifdef REPAIRMB_RSP_TIMEOUT_EN
        run(1'b0, 16'hFFFF, 0, -1, 2'b00, 2'b11, ERR, 21);
        run(1'b0, 16'hFFFF, 0, 19, 2'b11, 2'b11, CONT, 21);
`endif

        // abort in WAIT_RSP
        lq.push_back(2'b11);
        @(posedge CLK) #1;
        bus.i_start = 1'b1; bus.i_second_check = 1'b0;
        @(posedge CLK) #1;
        bus.i_result_valid = 1'b1; bus.i_lane_result = 16'hFFFF;
        @(posedge CLK) #1;
        bus.i_result_valid = 1'b0; bus.i_sb_ready = 1'b1;
        @(posedge CLK) #1;
        bus.i_sb_ready = 1'b0;
        @(posedge CLK) #1;
        bus.i_start = 1'b0;
        dc = done_cnt;
        @(posedge CLK) #1;
        bus.i_sb_rsp_valid = 1'b1; bus.i_sb_rsp_lanes = 2'b11;
        @(negedge CLK);
        check("abort_outputs", outs(), 7'b0);
        @(posedge CLK) #1;
        bus.i_sb_rsp_valid = 1'b0; bus.i_sb_rsp_lanes = 2'b00;
        repeat (3) @(posedge CLK);
        #1;
        check("abort_no_done", done_cnt, dc);

        // reset in SEND
        @(posedge CLK) #1;
        bus.i_start = 1'b1;
        @(posedge CLK) #1;
        bus.i_result_valid = 1'b1; bus.i_lane_result = 16'h00FF;
        @(posedge CLK) #1;
        bus.i_result_valid = 1'b0;
        @(negedge CLK);
        check("send_before_reset", {bus.o_sb_valid, bus.o_sb_lanes}, {1'b1, 2'b01});
        @(posedge CLK) #1;
        rst_n = 1'b0;
        @(posedge CLK) #1;
        @(negedge CLK);
        check("reset_in_send", outs(), 7'b0);
        @(posedge CLK) #1;
        rst_n = 1'b1; bus.i_start = 1'b0;

        // prev_code back to 00: second pass with no lanes continues
        run(1'b1, 16'h0000, 0, 1, 2'b00, 2'b00, CONT, 3);

        repeat (2) @(posedge CLK);
        check("lq_drained", lq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
